sha256_msg_padder: RTL and testbench
====================================

// Module: sha256_msg_padder
// PURPOSE
// - Streaming SHA-256 message front end: accepts message bytes over a valid/ready stream, appends FIPS 180-4 padding.
// - Padding is 0x80, zero fill, then the 64-bit big-endian message bit length.
// - Emits 512-bit blocks over a second valid/ready stream into the sha256 core.
// - Replaces the fixed 1024-bit hand-built input vector; supports arbitrary message length and multi-block output.
// PARAMETERS
// - IN_W       32  input beat width in bits; multiple of 8; must divide 512
// - BLK_CNT_W  16  width of emitted-block counter blk_idx
// PORTS
// - clk       in   1              single clock; all logic on rising edge
// - rst_n     in   1              synchronous, active-low reset
// - s_valid   in   1              input beat valid
// - s_ready   out  1              padder can accept a beat
// - s_data    in   IN_W           message bytes; first byte in [IN_W-1:IN_W-8]
// - s_nbytes  in   $clog2(IN_W/8)+1  valid bytes in beat; honoured only with s_last, range 0..IN_W/8
// - s_last    in   1              final beat of message
// - m_valid   out  1              block valid
// - m_ready   in   1              core accepts block
// - m_block   out  512            block; byte 0 at [511:504]
// - m_first   out  1              block is first of message
// - m_last    out  1              block is last of message; carries the length field
// - blk_idx   out  BLK_CNT_W      index of m_block within message, 0-based, wraps
// BEHAVIOUR
// - Reset (rst_n=0 at edge): m_valid=0, m_block=0, m_first=0, m_last=0, blk_idx=0, s_ready=0 for the reset cycle.
//   Byte pointer and 64-bit bit counter cleared; partial message discarded; FSM -> ACCUM. s_ready=1 the cycle after.
// - Transfers occur when valid&&ready at a clock edge. m_* hold stable while m_valid && !m_ready.
// - FSM ACCUM: shift beats into block buffer at byte pointer p (0..63); counter += 8*bytes taken.
//   Non-last beat: IN_W/8 bytes. If p reaches 64 -> EMIT with m_last=0.
// - On s_last accept, with n = (p + s_nbytes) mod 64 after the beat:
//   * beat fills the block exactly: emit it (m_last=0), then PAD1 = 0x80 | zeros | length.
//   * n<=55: single final block = data | 0x80 at byte n | zeros | length; m_last=1.
//   * 56<=n<=63: PAD0 block = data | 0x80 | zeros (m_last=0), then PAD1 = zeros | length (m_last=1).
// - States ACCUM, EMIT, PAD0, PAD1, WAIT. Next block is registered 1 cycle after the completing beat; m_valid rises then.
// - WAIT exists only without double buffering: block held until handshake.
// - s_ready=0 in EMIT/PAD0/PAD1/WAIT. Exception: double buffering, see CONFIGURATION.
// - After m_last handshake: counter, blk_idx and p clear; FSM -> ACCUM. The next message may start that cycle.
// - Length is the counter value, mod 2^64. blk_idx increments on each block handshake and wraps at 2^BLK_CNT_W.
// - m_first=1 only on blk_idx==0. s_nbytes=0 with s_last is legal (empty tail); empty message -> one block 0x80..00.
// - Unused bytes of a partial last beat are ignored (masked to zero in the block).
// CONFIGURATION
// - SHA256_PAD_DBL_BUF_EN defined: second 512-bit buffer.
//   * s_ready stays 1 while a completed block waits in the output register, as long as the fill buffer is not full.
//   * Sustains one beat per cycle with m_ready=1.
// - Undefined: single buffer; s_ready=0 from block completion until its handshake (and through PAD states).
// - Block contents and order are identical in both modes.
// TESTING
// - "abc": s_data=0x61626300, s_nbytes=3, s_last -> 1 block 0x61626380_00.._00000018; m_first=m_last=1.
// - Empty message (s_nbytes=0, s_last) -> 1 block 0x80 then zeros, length 0.
// - 56-byte message -> 2 blocks; block1 byte56=0x80; block2 all zero except length 0x1C0, m_last=1.
// - 64-byte message -> block0 data, m_last=0; block1 0x80.., length 0x200; blk_idx 0,1.
// - 90-byte ("abc" x30) -> 2 blocks, length 0x2D0; m_ready=0 for 5 cycles mid-stream -> m_block/m_valid stable, no beat lost.
// - rst_n=0 mid-message after 40 bytes, then "abc" -> output identical to the clean "abc" case.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: streaming FIPS 180-4 padder feeding 512-bit blocks to the sha256 core.
// Optional feature: define SHA256_PAD_DBL_BUF_EN for a second 512-bit (output) buffer.
module sha256_msg_padder #(
    parameter int IN_W      = 32,
    parameter int BLK_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [IN_W-1:0]         s_data,
    input  logic [$clog2(IN_W/8):0] s_nbytes,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [511:0]            m_block,
    output logic                    m_first,
    output logic                    m_last,
    output logic [BLK_CNT_W-1:0]    blk_idx
);

    localparam int NB = IN_W / 8;

`ifdef SHA256_PAD_DBL_BUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    typedef enum logic [2:0] {ACCUM, EMIT, PAD0, PAD1, WAIT} state_e;

    state_e state_q, state_d;
    state_e post_q, post_d;
    state_e after;

    // byte i of a block lives at index 63-i (i.e. ~i), so byte 0 lands in [511:504]
    logic [63:0][7:0]     buf_q, buf_d;
    logic [63:0][7:0]     out_q, out_d;
    logic [6:0]           p_q, p_d;
    logic [63:0]          cnt_q, cnt_d;
    logic                 out_v_q, out_v_d;
    logic                 out_last_q, out_last_d;
    logic                 fin_q, fin_d;
    logic                 pad1_q, pad1_d;
    logic                 mark_q, mark_d;
    logic [BLK_CNT_W-1:0] idx_q, idx_d;

    logic       out_free;
    logic       m_hs;
    logic       load;
    logic       beat;
    logic [6:0] base;
    logic [6:0] k;
    logic [6:0] n_end;

    assign out_free = !out_v_q || m_ready;
    assign m_hs     = out_v_q && m_ready;
    assign load     = (state_q == EMIT || state_q == PAD0 || state_q == PAD1) && out_free;

    // with two buffers a data block can leave the fill buffer while the next beat lands
    assign s_ready = rst_n && (state_q == ACCUM ||
                     (DBL && state_q == EMIT && load && !fin_q && !pad1_q));
    assign beat    = s_valid && s_ready;

    // beat placement: a beat taken during a load starts a fresh block at byte 0
    assign base  = load ? 7'd0 : p_q;
    assign k     = s_last ? 7'(s_nbytes) : 7'(NB);
    assign n_end = base + k;

    assign m_valid = out_v_q;
    assign m_block = out_q;
    assign m_last  = out_last_q;
    assign m_first = out_v_q && (idx_q == '0);
    assign blk_idx = idx_q;

    // where the FSM goes once the block being loaded has been handed off
    always_comb begin
        after = ACCUM;
        if (state_q == EMIT && pad1_q) after = PAD1;
        if (state_q == PAD0)           after = PAD1;
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    // next-state: drain completed blocks, then resume accumulation
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM:   state_d = ACCUM;
            EMIT,
            PAD0,
            PAD1:    if (load) state_d = DBL ? after : WAIT;
            WAIT:    if (m_hs) state_d = post_q;
            default: state_d = ACCUM;
        endcase
        if (beat && (s_last || n_end == 7'd64))
            state_d = (s_last && n_end >= 7'd56 && n_end < 7'd64) ? PAD0 : EMIT;
    end

    // datapath: fill buffer writes, output block formation, counters
    always_comb begin
        buf_d      = buf_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        out_v_d    = out_v_q && !m_ready;
        out_last_d = out_last_q;
        idx_d      = idx_q;
        fin_d      = fin_q;
        pad1_d     = pad1_q;
        mark_d     = mark_q;
        post_d     = post_q;

        if (m_hs) idx_d = out_last_q ? '0 : idx_q + 1'b1;

        if (load) begin
            out_v_d    = 1'b1;
            post_d     = after;
            out_last_d = 1'b0;
            unique case (state_q)
                EMIT: begin
                    out_d      = fin_q ? {buf_q[63:8], cnt_q} : buf_q;
                    out_last_d = fin_q;
                end
                PAD0:    out_d = buf_q;
                default: begin
                    out_d      = {(mark_q ? 8'h80 : 8'h00), 440'd0, cnt_q};
                    out_last_d = 1'b1;
                end
            endcase
            if (state_q != PAD1) begin
                buf_d = '0;
                p_d   = '0;
            end
            if (state_q == PAD1 || (state_q == EMIT && fin_q)) cnt_d = '0;
        end

        if (beat) begin
            for (int j = 0; j < NB; j++) begin
                if (7'(j) < k)
                    buf_d[~(base[5:0] + 6'(j))] = s_data[IN_W-1-8*j -: 8];
            end
            if (s_last && n_end < 7'd64) buf_d[~n_end[5:0]] = 8'h80;
            p_d    = n_end;
            cnt_d  = cnt_d + {54'd0, k, 3'd0};
            fin_d  = s_last && n_end <= 7'd55;
            pad1_d = s_last && n_end > 7'd55;
            mark_d = n_end == 7'd64;
        end
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q      <= '0;
            out_q      <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            out_v_q    <= 1'b0;
            out_last_q <= 1'b0;
            idx_q      <= '0;
            fin_q      <= 1'b0;
            pad1_q     <= 1'b0;
            mark_q     <= 1'b0;
            post_q     <= ACCUM;
        end else begin
            buf_q      <= buf_d;
            out_q      <= out_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            out_v_q    <= out_v_d;
            out_last_q <= out_last_d;
            idx_q      <= idx_d;
            fin_q      <= fin_d;
            pad1_q     <= pad1_d;
            mark_q     <= mark_d;
            post_q     <= post_d;
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: directed and randomized messages against a FIPS 180-4 padding model.
// Works with or without SHA256_PAD_DBL_BUF_EN; checks are handshake based.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = '0;
    logic [2:0]   s_nbytes = '0;
    logic         s_last = 1'b0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [511:0] m_block;
    logic         m_first;
    logic         m_last;
    logic [15:0]  blk_idx;

    int n_assert = 0;
    int n_fail = 0;

    byte unsigned msg [0:255];
    logic [511:0] exp_q [$];

    always #5 clk = ~clk;

    sha256_msg_padder #(.IN_W(32), .BLK_CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_nbytes (s_nbytes),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_block  (m_block),
        .m_first  (m_first),
        .m_last   (m_last),
        .blk_idx  (blk_idx)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length
    task automatic build_expected(input int len);
        byte unsigned pb [0:383];
        int total;
        logic [63:0] bits;
        logic [511:0] blk;
        exp_q.delete();
        total = ((len + 9 + 63) / 64) * 64;
        for (int i = 0; i < total; i++) pb[i] = 8'h00;
        for (int i = 0; i < len; i++) pb[i] = msg[i];
        pb[len] = 8'h80;
        bits = 64'(len) * 64'd8;
        for (int i = 0; i < 8; i++) pb[total-1-i] = bits[8*i +: 8];
        for (int b = 0; b < total / 64; b++) begin
            for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = pb[64*b+i];
            exp_q.push_back(blk);
        end
    endtask

    task automatic drive_beat(input int bi, input int nbeat, input int len);
        s_last = (bi == nbeat - 1);
        s_nbytes = s_last ? 3'(len - 4*bi) : 3'($urandom_range(0, 4));
        for (int j = 0; j < 4; j++) begin
            int ix;
            ix = 4*bi + j;
            s_data[31-8*j -: 8] = (ix < len) ? msg[ix] : 8'($urandom);
        end
    endtask

    // tail: 1 = send a whole-word message with an extra empty last beat
    task automatic run_msg(input int len, input int tail, input bit rnd, input bit stall5);
        int nbeat, bi, bo, hold, cyc;
        bit stalled, b_fire, prev_hold;
        logic [511:0] prev_blk;
        build_expected(len);
        if (len % 4 != 0 || len == 0) nbeat = len / 4 + 1;
        else nbeat = len / 4 + tail;
        bi = 0; bo = 0; hold = 0; cyc = 0;
        stalled = 0; prev_hold = 0; prev_blk = '0;
        s_valid = 1'b0;
        while ((bi < nbeat || bo < exp_q.size()) && cyc < 3000) begin
            if (bi < nbeat) begin
                if (!s_valid) s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                drive_beat(bi, nbeat, len);
            end else begin
                s_valid = 1'b0;
                s_last = 1'b0;
            end
            if (stall5 && !stalled && m_valid) begin
                hold = 5;
                stalled = 1;
            end
            m_ready = (hold > 0) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            @(negedge clk);
            if (prev_hold) begin
                check("hold_valid", m_valid, 1'b1);
                check("hold_block", m_block, prev_blk);
            end
            if (m_valid && m_ready) begin
                if (bo < exp_q.size()) begin
                    check($sformatf("len%0d_blk%0d", len, bo), m_block, exp_q[bo]);
                    check("m_first", m_first, bo == 0);
                    check("m_last", m_last, bo == exp_q.size() - 1);
                    check("blk_idx", blk_idx, 16'(bo));
                end else begin
                    check("extra_block", m_valid, 1'b0);
                end
                bo++;
            end
            b_fire = s_valid && s_ready;
            prev_hold = m_valid && !m_ready;
            prev_blk = m_block;
            @(posedge clk); #1;
            if (b_fire) begin
                bi++;
                s_valid = 1'b0;
            end
            if (hold > 0) hold--;
            cyc++;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        m_ready = 1'b1;
        check($sformatf("len%0d_complete", len), {bi == nbeat, bo == exp_q.size()}, 2'b11);
        repeat (2) begin
            @(negedge clk);
            check("idle_m_valid", m_valid, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    task automatic set_abc(input int reps);
        for (int i = 0; i < 3*reps; i++) msg[i] = 8'h61 + 8'(i % 3);
    endtask

    task automatic set_random(input int len);
        for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
    endtask

    task automatic check_reset_values();
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_block", m_block, 512'd0);
        check("rst_m_first", m_first, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_blk_idx", blk_idx, 16'd0);
        check("rst_s_ready", s_ready, 1'b0);
    endtask

    initial begin
        int fired, cyc;
        bit b;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 1'b1);
        @(posedge clk); #1;

        set_abc(1);
        run_msg(3, 0, 0, 0);

        run_msg(0, 0, 0, 0);

        set_random(56);
        run_msg(56, 0, 0, 0);

        set_random(64);
        run_msg(64, 0, 0, 0);
        run_msg(64, 1, 1, 0);

        set_random(55);
        run_msg(55, 0, 1, 0);

        set_random(63);
        run_msg(63, 0, 1, 0);

        set_abc(30);
        run_msg(90, 0, 0, 1);

        fired = 0;
        cyc = 0;
        m_ready = 1'b1;
        while (fired < 10 && cyc < 100) begin
            s_valid = 1'b1;
            s_last = 1'b0;
            s_nbytes = 3'd4;
            s_data = $urandom;
            @(negedge clk);
            b = s_ready;
            @(posedge clk); #1;
            if (b) fired++;
            cyc++;
        end
        check("pre_reset_beats", fired, 10);
        s_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_values();
        rst_n = 1'b1;
        set_abc(1);
        run_msg(3, 0, 0, 0);

        for (int t = 0; t < 8; t++) begin
            int len;
            len = $urandom_range(0, 200);
            set_random(len);
            run_msg(len, $urandom_range(0, 1), 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
